// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 operand-issue stage.
// A request is the three fp16 operands plus the operation control bits.
package fma16_pkg;

    typedef struct packed {
        logic [1:0] roundmode;
        logic       mul;
        logic       add;
        logic       negp;
        logic       negz;
    } fma_ctrl_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        fma_ctrl_t   ctrl;
    } fma_req_t;

    localparam int REQ_W  = $bits(fma_req_t);
    localparam int NFLAGS = 4;

    // Bit positions within the {Invalid, Overflow, Underflow, Inexact} flag vector
    localparam int FLG_NV = 3;
    localparam int FLG_OF = 2;
    localparam int FLG_UF = 1;
    localparam int FLG_NX = 0;

    // Clear takes effect before the newly captured flags are merged in
    function automatic logic [NFLAGS-1:0] merge_flags(
        input logic [NFLAGS-1:0] sticky,
        input logic [NFLAGS-1:0] fresh,
        input logic              clr
    );
        return clr ? fresh : (sticky | fresh);
    endfunction

endpackage

// File: rtl/fma16_req_fifo.sv
// Circular request buffer with occupancy count. The head entry is read
// combinationally so it can feed the fma16 datapath in the same cycle.
module fma16_req_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 54,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_reg[wr_ptr_reg] <= wr_data;
    end

    assign rd_data = mem_reg[rd_ptr_reg];
    assign count   = count_reg;

endmodule

// File: rtl/fma16_issue_q.sv
// Buffers fma16 requests, presents the oldest to the external fma16 datapath,
// and registers its result/flags into a handshaked output stage with sticky flags.
module fma16_issue_q
    import fma16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [15:0]                in_x,
    input  logic [15:0]                in_y,
    input  logic [15:0]                in_z,
    input  logic [5:0]                 in_ctrl,
    output logic [15:0]                fma_x,
    output logic [15:0]                fma_y,
    output logic [15:0]                fma_z,
    output logic [1:0]                 fma_roundmode,
    output logic                       fma_mul,
    output logic                       fma_add,
    output logic                       fma_negp,
    output logic                       fma_negz,
    input  logic [15:0]                fma_result,
    input  logic [3:0]                 fma_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_result,
    output logic [3:0]                 out_flags,
    output logic [3:0]                 sticky_flags,
    input  logic                       sticky_clr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    fma_req_t          in_req;
    fma_req_t          head;
    fma_req_t          issue;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              capture;
    logic [NFLAGS-1:0] cap_flags;

    logic              out_valid_reg;
    logic [15:0]       out_result_reg;
    logic [NFLAGS-1:0] out_flags_reg;
    logic [NFLAGS-1:0] sticky_reg;

    assign in_req   = {in_x, in_y, in_z, in_ctrl};
    assign in_ready = ~fifo_full;
    assign push     = in_valid & in_ready;
    assign capture  = ~fifo_empty & (~out_valid_reg | out_ready);

    fma16_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_data (in_req),
        .rd_en   (capture),
        .rd_data (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Stale memory contents must never reach fma16 when nothing is queued
    assign issue         = fifo_empty ? '0 : head;
    assign fma_x         = issue.x;
    assign fma_y         = issue.y;
    assign fma_z         = issue.z;
    assign fma_roundmode = issue.ctrl.roundmode;
    assign fma_mul       = issue.ctrl.mul;
    assign fma_add       = issue.ctrl.add;
    assign fma_negp      = issue.ctrl.negp;
    assign fma_negz      = issue.ctrl.negz;

    assign cap_flags = capture ? fma_flags : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= '0;
            out_flags_reg  <= '0;
            sticky_reg     <= '0;
        end else begin
            if (capture) begin
                out_valid_reg  <= 1'b1;
                out_result_reg <= fma_result;
                out_flags_reg  <= fma_flags;
            end else if (out_ready) begin
                out_valid_reg  <= 1'b0;
            end
            sticky_reg <= merge_flags(sticky_reg, cap_flags, sticky_clr);
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_result   = out_result_reg;
    assign out_flags    = out_flags_reg;
    assign sticky_flags = sticky_reg;

endmodule

// File: tb/tb_fma16_issue_q.sv
// Directed and randomized bench for fma16_issue_q; a stand-in fma16 maps each
// request to a result, and a queue-based model predicts every output.
module tb_fma16_issue_q;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x, in_y, in_z;
    logic [5:0]  in_ctrl;
    logic [15:0] fma_x, fma_y, fma_z;
    logic [1:0]  fma_roundmode;
    logic        fma_mul, fma_add, fma_negp, fma_negz;
    logic [15:0] fma_result;
    logic [3:0]  fma_flags;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_flags;
    logic [3:0]  sticky_flags;
    logic        sticky_clr;
    logic [2:0]  count;

    fma16_issue_q #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_x          (in_x),
        .in_y          (in_y),
        .in_z          (in_z),
        .in_ctrl       (in_ctrl),
        .fma_x         (fma_x),
        .fma_y         (fma_y),
        .fma_z         (fma_z),
        .fma_roundmode (fma_roundmode),
        .fma_mul       (fma_mul),
        .fma_add       (fma_add),
        .fma_negp      (fma_negp),
        .fma_negz      (fma_negz),
        .fma_result    (fma_result),
        .fma_flags     (fma_flags),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_flags     (out_flags),
        .sticky_flags  (sticky_flags),
        .sticky_clr    (sticky_clr),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in fma16: exact values for the listed fp16 cases, otherwise a hash
    function automatic logic [19:0] fake_fma(input logic [53:0] r);
        logic [15:0] x, y, z;
        logic [5:0]  c;
        x = r[53:38]; y = r[37:22]; z = r[21:6]; c = r[5:0];
        if (r == {16'h3C00, 16'h4000, 16'h0000, 6'h18}) return {16'h4000, 4'b0000};
        if (r == {16'h4000, 16'h4000, 16'h0000, 6'h18}) return {16'h4400, 4'b0000};
        if (r == {16'h3C00, 16'h4000, 16'h3C00, 6'h1C}) return {16'h4200, 4'b0000};
        if (r == {16'h7BFF, 16'h4000, 16'h0000, 6'h18}) return {16'h7C00, 4'b0101};
        if (r == {16'h7C00, 16'h0000, 16'h0000, 6'h18}) return {16'h7E00, 4'b1000};
        return {x ^ {y[7:0], y[15:8]} ^ (z + {10'd0, c}), x[3:0] ^ y[7:4] ^ c[3:0]};
    endfunction

    assign {fma_result, fma_flags} = fake_fma({fma_x, fma_y, fma_z, fma_roundmode,
                                               fma_mul, fma_add, fma_negp, fma_negz});

    // Reference model: pending requests in order, plus the output register contents
    logic [53:0] mq[$];
    logic        m_valid, m_known;
    logic [15:0] m_res;
    logic [3:0]  m_flg, m_sticky;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [5:0] c);
        in_valid = v; in_x = x; in_y = y; in_z = z; in_ctrl = c;
    endtask

    task automatic cycle();
        logic        exp_rdy, cap;
        logic [53:0] head, push_r;
        logic [19:0] fr;
        logic [3:0]  fresh;
        exp_rdy = (mq.size() != DEPTH);
        cap     = (mq.size() != 0) && (!m_valid || out_ready);
        head    = (mq.size() != 0) ? mq[0] : 54'd0;
        if (m_known) begin
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            check("fma_issue", 64'({fma_x, fma_y, fma_z, fma_roundmode, fma_mul,
                                    fma_add, fma_negp, fma_negz}), 64'(head));
        end
        push_r = {in_x, in_y, in_z, in_ctrl};
        @(posedge clk);
        if (!reset) begin
            mq.delete();
            m_valid = 1'b0; m_res = '0; m_flg = '0; m_sticky = '0; m_known = 1'b1;
        end else begin
            if (m_valid && out_ready)
                $display("take result=%h flags=%b", m_res, m_flg);
            fresh = 4'b0000;
            if (cap) begin
                fr = fake_fma(mq.pop_front());
                m_res = fr[19:4]; m_flg = fr[3:0]; fresh = fr[3:0];
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            m_sticky = sticky_clr ? fresh : (m_sticky | fresh);
            if (in_valid && exp_rdy) mq.push_back(push_r);
        end
        #1;
        if (m_known) begin
            check("count", 64'(count), 64'(mq.size()));
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("out_result", 64'(out_result), 64'(m_res));
            check("out_flags", 64'(out_flags), 64'(m_flg));
            check("sticky", 64'(sticky_flags), 64'(m_sticky));
        end
    endtask

    initial begin
        m_known = 1'b0; m_valid = 1'b0; m_res = '0; m_flg = '0; m_sticky = '0;
        reset = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
        drive(1'b1, 16'h1234, 16'h5678, 16'h9ABC, 6'h15);
        #2;
        // Reset for two cycles with a request offered: nothing may be enqueued
        cycle();
        cycle();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        reset = 1'b1;

        // Single request, one cycle latency
        out_ready = 1'b1;
        drive(1'b1, 16'h3C00, 16'h4000, 16'h0000, 6'h18);
        cycle();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 6'h0);
        cycle();
        check("single_res", 64'(out_result), 64'h4000);
        check("single_valid", 64'(out_valid), 64'd1);
        cycle();

        // Back-to-back stream
        drive(1'b1, 16'h3C00, 16'h4000, 16'h0000, 6'h18); cycle();
        drive(1'b1, 16'h4000, 16'h4000, 16'h0000, 6'h18); cycle();
        check("stream_res0", 64'(out_result), 64'h4000);
        drive(1'b1, 16'h3C00, 16'h4000, 16'h3C00, 6'h1C); cycle();
        check("stream_res1", 64'(out_result), 64'h4400);
        drive(1'b0, 16'h0, 16'h0, 16'h0, 6'h0); cycle();
        check("stream_res2", 64'(out_result), 64'h4200);
        cycle();

        // Backpressure: fill to DEPTH, sixth request refused, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 6'($urandom));
            cycle();
        end
        check("bp_count", 64'(count), 64'd4);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        drive(1'b0, 16'h0, 16'h0, 16'h0, 6'h0);
        out_ready = 1'b1;
        repeat (7) cycle();

        // Exception flags and sticky accumulation / clear-with-capture
        sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
        drive(1'b1, 16'h7BFF, 16'h4000, 16'h0000, 6'h18); cycle();
        drive(1'b1, 16'h7C00, 16'h0000, 16'h0000, 6'h18); cycle();
        check("ovf_flags", 64'(out_flags), 64'b0101);
        drive(1'b0, 16'h0, 16'h0, 16'h0, 6'h0); cycle();
        check("nv_result", 64'(out_result), 64'h7E00);
        check("sticky_acc", 64'(sticky_flags), 64'b1101);
        drive(1'b1, 16'h7C00, 16'h0000, 16'h0000, 6'h18); cycle();
        drive(1'b0, 16'h0, 16'h0, 16'h0, 6'h0);
        sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0;
        check("sticky_clr_cap", 64'(sticky_flags), 64'b1000);
        cycle();

        // Reset mid-operation discards queued entries and held result
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'($urandom), 16'($urandom), 16'($urandom), 6'($urandom));
            cycle();
        end
        check("pre_rst_count", 64'(count), 64'd3);
        drive(1'b0, 16'h0, 16'h0, 16'h0, 6'h0);
        reset = 1'b0; cycle(); reset = 1'b1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        repeat (4) cycle();

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
                  16'($urandom), 6'($urandom));
            out_ready  = $urandom_range(0, 2) != 0;
            sticky_clr = $urandom_range(0, 15) == 0;
            reset      = $urandom_range(0, 99) != 0;
            cycle();
        end
        reset = 1'b1; sticky_clr = 1'b0; out_ready = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 6'h0);
        repeat (8) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
